// File: rtl/rca_lsq_row_arbiter_if.sv
// rca_lsq_row_arbiter_if: memory request/response bundle between the LSQ row arbiter and memory.
// Ports: mem_req_valid/mem_req_ready handshake, mem_addr/mem_data/mem_fn3/mem_load/mem_store request
// fields, mem_rdata_valid/mem_rdata load response. master = arbiter side, slave = memory side.
interface rca_lsq_row_arbiter_if #(
    parameter int XLEN = 32
);
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic [2:0]      mem_fn3;
    logic            mem_load;
    logic            mem_store;
    logic            mem_rdata_valid;
    logic [XLEN-1:0] mem_rdata;
    modport master (
        output mem_req_valid, mem_addr, mem_data, mem_fn3, mem_load, mem_store,
        input  mem_req_ready, mem_rdata_valid, mem_rdata
    );
    modport slave (
        input  mem_req_valid, mem_addr, mem_data, mem_fn3, mem_load, mem_store,
        output mem_req_ready, mem_rdata_valid, mem_rdata
    );
endinterface

// File: rtl/rca_lsq_row_arbiter.sv
// rca_lsq_row_arbiter: round-robin arbiter merging per-row load/store slots into one memory port.
// Ports: clk; rst (asynchronous, active-low); flush discards all requests and marks queued tags stale;
// row_* per-row request capture with row_busy back-pressure; mem (master modport) request FIFO head
// and load response; load_data/load_complete registered load return, pulse indexed by row.
// Optional: define RCA_LSQ_ARB_STATS_EN to add saturating stat_grants and stat_stall_cycles outputs.
module rca_lsq_row_arbiter #(
    parameter int NUM_ROWS   = 3,
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NUM_ROWS-1:0]            row_new_request,
    input  logic [NUM_ROWS-1:0]            row_load,
    input  logic [NUM_ROWS-1:0]            row_store,
    input  logic [NUM_ROWS-1:0][XLEN-1:0]  row_addr,
    input  logic [NUM_ROWS-1:0][XLEN-1:0]  row_data,
    input  logic [NUM_ROWS-1:0][2:0]       row_fn3,
    output logic [NUM_ROWS-1:0]            row_busy,
    rca_lsq_row_arbiter_if.master          mem,
    output logic [XLEN-1:0]                load_data,
    output logic [NUM_ROWS-1:0]            load_complete
`ifdef RCA_LSQ_ARB_STATS_EN
    ,
    output logic [31:0]                    stat_grants,
    output logic [31:0]                    stat_stall_cycles
`endif
);
    localparam int RW = NUM_ROWS > 1 ? $clog2(NUM_ROWS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NUM_ROWS-1:0]           pending, p_load, capture, elig, grant;
    logic [NUM_ROWS-1:0][XLEN-1:0] p_addr, p_data;
    logic [NUM_ROWS-1:0][2:0]      p_fn3;
    logic [RW-1:0]                 rr_ptr, g_idx, cand;
    logic                          found, do_grant, g_load;

    logic [XLEN-1:0] f_addr [FIFO_DEPTH];
    logic [XLEN-1:0] f_data [FIFO_DEPTH];
    logic [2:0]      f_fn3  [FIFO_DEPTH];
    logic            f_load [FIFO_DEPTH];
    logic [RW-1:0]   f_row  [FIFO_DEPTH];
    logic [AW-1:0]   f_wr, f_rd;
    logic [AW:0]     f_cnt;
    logic            f_full, pop, can_push;

    logic [RW-1:0]         t_row [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] t_stale;
    logic [AW-1:0]         t_wr, t_rd;
    logic [AW:0]           t_cnt, t_cnt_n, inflight;
    logic                  tag_push, rsp, load_ok;

    assign row_busy  = pending;
    assign capture   = row_new_request & (row_load ^ row_store) & ~pending;
    assign f_full    = f_cnt == (AW+1)'(FIFO_DEPTH);
    assign pop       = mem.mem_req_valid & mem.mem_req_ready;
    assign can_push  = ~f_full | pop;

    // Loads are admitted against a credit covering both FIFO-resident loads and issued tags,
    // so the tag queue can never overflow when a load later pops from the FIFO.
    assign load_ok   = inflight != (AW+1)'(FIFO_DEPTH);
    assign elig      = pending & (~p_load | {NUM_ROWS{load_ok}});

    assign mem.mem_req_valid = f_cnt != '0;
    assign mem.mem_addr      = f_addr[f_rd];
    assign mem.mem_data      = f_data[f_rd];
    assign mem.mem_fn3       = f_fn3[f_rd];
    assign mem.mem_load      = mem.mem_req_valid & f_load[f_rd];
    assign mem.mem_store     = mem.mem_req_valid & ~f_load[f_rd];

    assign tag_push = pop & f_load[f_rd];
    assign rsp      = mem.mem_rdata_valid & (t_cnt != '0);
    assign t_cnt_n  = t_cnt + (AW+1)'(tag_push) - (AW+1)'(rsp);

    always_comb begin
        found = 1'b0;
        g_idx = '0;
        cand  = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            cand = RW'((int'(rr_ptr) + i) % NUM_ROWS);
            if (!found && elig[cand]) begin
                found = 1'b1;
                g_idx = cand;
            end
        end
    end

    assign do_grant = found & can_push & ~flush;
    assign g_load   = p_load[g_idx];
    assign grant    = do_grant ? NUM_ROWS'(1) << g_idx : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            p_load  <= '0;
            p_addr  <= '0;
            p_data  <= '0;
            p_fn3   <= '0;
            rr_ptr  <= '0;
        end else begin
            pending <= flush ? '0 : (pending & ~grant) | capture;
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (capture[r]) begin
                    p_load[r] <= row_load[r];
                    p_addr[r] <= row_addr[r];
                    p_data[r] <= row_data[r];
                    p_fn3[r]  <= row_fn3[r];
                end
            end
            if (do_grant)
                rr_ptr <= g_idx == RW'(NUM_ROWS - 1) ? '0 : g_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_grant) begin
            f_addr[f_wr] <= p_addr[g_idx];
            f_data[f_wr] <= p_data[g_idx];
            f_fn3[f_wr]  <= p_fn3[g_idx];
            f_load[f_wr] <= g_load;
            f_row[f_wr]  <= g_idx;
        end
        if (tag_push)
            t_row[t_wr] <= f_row[f_rd];
    end

    // A load accepted by memory on the flush edge still gets a (stale) tag: its response will arrive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_wr     <= '0;
            f_rd     <= '0;
            f_cnt    <= '0;
            t_wr     <= '0;
            t_rd     <= '0;
            t_cnt    <= '0;
            t_stale  <= '0;
            inflight <= '0;
        end else begin
            f_wr     <= flush ? '0 : f_wr + AW'(do_grant);
            f_rd     <= flush ? '0 : f_rd + AW'(pop);
            f_cnt    <= flush ? '0 : f_cnt + (AW+1)'(do_grant) - (AW+1)'(pop);
            t_wr     <= t_wr + AW'(tag_push);
            t_rd     <= t_rd + AW'(rsp);
            t_cnt    <= t_cnt_n;
            inflight <= flush ? t_cnt_n : inflight + (AW+1)'(do_grant & g_load) - (AW+1)'(rsp);
            if (flush)
                t_stale <= '1;
            if (tag_push)
                t_stale[t_wr] <= flush;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_data     <= '0;
            load_complete <= '0;
        end else begin
            load_complete <= rsp & ~t_stale[t_rd] & ~flush ? NUM_ROWS'(1) << t_row[t_rd] : '0;
            load_data     <= rsp ? mem.mem_rdata : load_data;
        end
    end

`ifdef RCA_LSQ_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_grants       <= '0;
            stat_stall_cycles <= '0;
        end else begin
            stat_grants       <= stat_grants + 32'(do_grant & ~&stat_grants);
            stat_stall_cycles <= stat_stall_cycles +
                                 32'(mem.mem_req_valid & ~mem.mem_req_ready & ~&stat_stall_cycles);
        end
    end
`endif
endmodule

// File: doc/rca_lsq_row_arbiter.md
RCA_LSQ_ROW_ARBITER -- requirements
Module: rca_lsq_row_arbiter

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 3: number of grid rows with a load/store slot.
REQ-002 SHALL have parameter XLEN, default 32: data and address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2): depth of the request FIFO and of the load-tag queue.
REQ-004 SHALL have ports (clock and reset first): clk in 1 clock; rst in 1 reset; flush in 1 discard all requests (partial reconfiguration in progress).
REQ-005 SHALL have per-row request ports: row_new_request in [NUM_ROWS] request pulse; row_load, row_store in [NUM_ROWS] operation type; row_addr, row_data in [NUM_ROWS][XLEN]; row_fn3 in [NUM_ROWS][3]; row_busy out [NUM_ROWS] row must not issue.
REQ-006 SHALL have memory ports: mem_req_valid out 1; mem_req_ready in 1; mem_addr, mem_data out XLEN; mem_fn3 out 3; mem_load, mem_store out 1; mem_rdata_valid in 1; mem_rdata in XLEN.
REQ-007 SHALL have return ports: load_data out XLEN; load_complete out [NUM_ROWS] one-cycle pulse.
REQ-008 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-009 SHALL hold one pending register per row; row_new_request with row_load or row_store set and row_busy low captures addr/data/fn3/type on the next clk edge and sets pending.
REQ-010 SHALL drive row_busy[r] = pending[r], so a row never has more than one un-arbitrated request.
REQ-011 SHALL ignore row_new_request while row_busy is high, and ignore requests with neither or both of row_load and row_store set.
REQ-012 SHALL grant at most one pending row per cycle into the request FIFO, round-robin from the row after the last granted row, only when the FIFO is not full and, for loads, the tag queue is not full.
REQ-013 SHALL clear pending[r] on the edge on which row r is granted; row r may present a new request in the cycle after row_busy falls.
REQ-014 SHALL drive mem_req_valid high whenever the FIFO is non-empty, with mem_* fields taken from the FIFO head; the head pops on mem_req_valid and mem_req_ready both high.
REQ-015 SHALL push the row index into the tag queue when a load pops from the FIFO; stores push no tag.
REQ-016 SHALL, on mem_rdata_valid, pop the tag queue, register mem_rdata into load_data, and pulse load_complete[tag] for exactly one cycle, one cycle after mem_rdata_valid.
REQ-017 SHALL treat mem_rdata_valid with an empty tag queue as a protocol error and ignore it.
REQ-018 SHALL support FIFO push and pop in the same cycle when full; occupancy stays unchanged.
REQ-019 SHALL, on flush, clear all pending registers and empty the FIFO on the next edge; flush has priority over a capture or grant in the same cycle.
REQ-020 SHALL, on flush, mark all queued tags stale; responses for stale tags pop the queue without pulsing load_complete.
REQ-021 SHALL provide request-to-mem_req_valid latency of 2 cycles when idle (capture, grant).

Reset
REQ-022 SHALL, with rst low, asynchronously clear pending, FIFO, tag queue, and round-robin pointer (next grant starts at row 0).
REQ-023 SHALL drive row_busy, mem_req_valid, and load_complete to 0 and load_data to 0 while in reset.

Configuration
REQ-024 SHALL, with macro RCA_LSQ_ARB_STATS_EN defined, add outputs stat_grants (32 bits, count of grants) and stat_stall_cycles (32 bits, cycles with mem_req_valid high and mem_req_ready low), both reset to 0, saturating, and unaffected by flush.
REQ-025 SHALL, without RCA_LSQ_ARB_STATS_EN, omit both ports and both counters, with all other behaviour identical.

Verification
REQ-026 Rows 0,1,2 request in the same cycle, mem_req_ready=1 -> mem_addr order is row0, row1, row2 on consecutive cycles; next round starts at row 0.
REQ-027 mem_req_ready=0 with 6 requests, FIFO_DEPTH=4 -> 4 entries queued, the remaining rows hold row_busy=1, no loss after ready rises.
REQ-028 Load from row 2, addr 0x100; mem_rdata=0xDEADBEEF -> load_data=0xDEADBEEF and load_complete=3'b100 for one cycle, one cycle after mem_rdata_valid.
REQ-029 Two loads outstanding, flush, then 2 responses -> no load_complete pulses; a new request after the flush completes normally.
REQ-030 rst low while FIFO holds 3 entries -> mem_req_valid=0 immediately; after release the first grant goes to row 0.
REQ-031 Store from row 1 -> mem_store=1 with mem_data and mem_fn3 equal to the captured values; no tag pushed and no load_complete.
